// File: rtl/data_mem_responder.sv
// data_mem_responder
//  Responder for the core's data-memory port. A load/store request is
//  accepted in IDLE, performed against an internal word array after LATENCY
//  cycles, and completed with a one-cycle rsp_valid_o pulse. The core holds
//  PC and register write-back while stall_o is high.
// Ports
//  clk          clock, all state on rising edge
//  rst          asynchronous active-high reset
//  req_i        access request, fields stable until rsp_valid_o
//  we_i         1 = store, 0 = load
//  size_i       funct3 size: 0 B, 1 H, 2 W, 4 BU, 5 HU
//  addr_i       byte address
//  wdata_i      right-aligned store data
//  rdata_o      load result (registered, held until next response)
//  rsp_valid_o  one-cycle completion pulse
//  err_o        misaligned / out-of-range / bad size, valid with rsp_valid_o
//  stall_o      req_i & ~rsp_valid_o (combinational)
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  size_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        rsp_valid_o,
   output logic        err_o,
   output logic        stall_o
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               we_q;
   logic [2:0]         size_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;

   logic [31:0]        mem [DEPTH_WORDS];

   logic [IDX_W-1:0]   idx;
   logic               size_bad;
   logic               misaligned;
   logic               out_of_range;
   logic               acc_err;
   logic [31:0]        word;
   logic [31:0]        shifted;
   logic [31:0]        load_data;
   logic [3:0]         be;
   logic [31:0]        wdata_sh;
   logic               mem_we;

   // Stall the core until the response pulse arrives
   assign stall_o = req_i & ~rsp_valid_o;

   // Access checks on the latched request
   always_comb begin
      idx          = addr_q[IDX_W+1:2];
      size_bad     = (size_q == 3'd3) || (size_q == 3'd6) || (size_q == 3'd7);
      misaligned   = (((size_q == 3'd1) || (size_q == 3'd5)) && addr_q[0]) ||
                     ((size_q == 3'd2) && (addr_q[1:0] != 2'b00));
      out_of_range = addr_q[31:2] >= 30'(DEPTH_WORDS);
      acc_err      = size_bad || misaligned || out_of_range;
   end

   // Load path: align the addressed bytes to bit 0, then extend
   always_comb begin
      word = '0;
      if (!out_of_range) word = mem[idx];
      shifted = word >> {addr_q[1:0], 3'b000};
      case (size_q)
         3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'd4:    load_data = {24'b0, shifted[7:0]};
         3'd5:    load_data = {16'b0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   // Store path: byte-lane enables and lane-aligned write data
   always_comb begin
      case (size_q[1:0])
         2'd0:    be = 4'b0001 << addr_q[1:0];
         2'd1:    be = 4'b0011 << {addr_q[1], 1'b0};
         default: be = 4'b1111;
      endcase
      wdata_sh = wdata_q << {addr_q[1:0], 3'b000};
   end

   // Store commits on the edge leaving RESP; a reset in flight suppresses it
   assign mem_we = (state == ST_RESP) && we_q && !acc_err && !rst;

   // Word array, not reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   // Control FSM and registered response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         we_q        <= 1'b0;
         size_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_o     <= '0;
         rsp_valid_o <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         rsp_valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A request still held in the response cycle is the old one
               if (req_i && !rsp_valid_o) begin
                  we_q    <= we_i;
                  size_q  <= size_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  cnt     <= CNT_W'(LATENCY - 1);
                  state   <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= ST_RESP;
            end
            ST_RESP: begin
               rsp_valid_o <= 1'b1;
               err_o       <= acc_err;
               rdata_o     <= (acc_err || we_q) ? 32'h0 : load_data;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
